// File: rtl/frame_prev_buf.sv
// frame_prev_buf
//   Previous-frame store for frame_diff. Every live frame is written into an
//   on-chip RAM. In the same access, the co-located pixel of the previous
//   frame is read back. The live stream comes out one cycle later, together
//   with the aligned previous-frame pixel.
//
// Ports
//   clk, rst_n                 pixel clock, asynchronous active-low reset
//   in_vsync/in_hsync/in_valid live stream control (vsync high during frame)
//   in_data[7:0]               live grey pixel
//   out_vsync/hsync/valid/data live stream delayed by one cycle
//   prev_data[7:0]             previous-frame pixel aligned to out_data
//   prev_ok                    prev_data comes from a complete, correctly sized frame
//   frame_err                  one-cycle pulse: the finished frame's pixel count != DEPTH
module frame_prev_buf #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int DEPTH = IMG_W * IMG_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vsync,
  input  logic       in_hsync,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] prev_data,
  output logic       prev_ok,
  output logic       frame_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SAT_C   = CW'(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t        state_q, state_d;
  // The address counter is one bit wider than the RAM index so that it can
  // hold the value DEPTH, which marks an overflowed frame.
  logic [CW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vsync_d_q;
  logic          armed_q, armed_d;
  logic          out_vsync_q, out_hsync_q, out_valid_q;
  logic [7:0]    out_data_q;
  logic          prev_sel_q, prev_sel_d;
  logic          prev_ok_q, prev_ok_d;
  logic          frame_err_q, frame_err_d;

  logic          frame_start;
  logic [CW-1:0] base_addr, base_cnt;
  logic          access, ram_we;
  logic [AW-1:0] ram_addr;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_q;

  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    // After a reset, leaving IDLE requires vsync to have been seen low first.
    // Without this, a reset released in the middle of a frame would look like
    // a frame start, because vsync_d resets to 0.
    armed_d     = armed_q | ~in_vsync;
    frame_start = in_vsync & ~vsync_d_q;

    if (frame_start) begin
      unique case (state_q)
        S_IDLE: if (armed_q) state_d = S_FILL;
        S_FILL, S_RUN: begin
          if (cnt_q == DEPTH_C) begin
            state_d = S_RUN;
          end else begin
            state_d     = S_FILL;
            frame_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A pixel arriving on the frame-start cycle belongs to the new frame.
    base_addr = frame_start ? '0 : addr_q;
    base_cnt  = frame_start ? '0 : cnt_q;

    access   = in_valid & in_vsync & (state_d != S_IDLE);
    ram_we   = access & (base_addr < DEPTH_C);
    ram_addr = base_addr[AW-1:0];

    addr_d = ram_we ? base_addr + 1'b1 : base_addr;
    cnt_d  = base_cnt;
    if (access && base_cnt != SAT_C) cnt_d = base_cnt + 1'b1;

    prev_ok_d  = (state_d == S_RUN);
    // Outside a valid in-range access, prev_data mirrors out_data so that the
    // downstream difference is zero.
    prev_sel_d = ram_we & (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      vsync_d_q   <= 1'b0;
      armed_q     <= 1'b0;
      out_vsync_q <= 1'b0;
      out_hsync_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      prev_sel_q  <= 1'b0;
      prev_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      vsync_d_q   <= in_vsync;
      armed_q     <= armed_d;
      out_vsync_q <= in_vsync;
      out_hsync_q <= in_hsync;
      out_valid_q <= in_valid;
      out_data_q  <= in_data;
      prev_sel_q  <= prev_sel_d;
      prev_ok_q   <= prev_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Single-port RAM: the read returns the old contents of the address being
  // written.
  always_ff @(posedge clk) begin
    rd_data_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= in_data;
  end

  // Output stage: registered one cycle after the inputs
  assign out_vsync = out_vsync_q;
  assign out_hsync = out_hsync_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign prev_data = prev_sel_q ? rd_data_q : out_data_q;
  assign prev_ok   = prev_ok_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_prev_buf.sv
module tb_frame_prev_buf;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vsync, in_hsync, in_valid;
  logic [7:0] in_data;
  logic       out_vsync, out_hsync, out_valid;
  logic [7:0] out_data, prev_data;
  logic       prev_ok, frame_err;

  frame_prev_buf #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_valid(in_valid), .in_data(in_data),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_valid(out_valid), .out_data(out_data),
    .prev_data(prev_data), .prev_ok(prev_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame bookkeeping in plain terms
  bit         m_active;   // a frame has been started since reset
  bit         m_good;     // the last finished frame had exactly D pixels
  bit         m_armed;    // vsync seen low since reset
  bit         m_lastvs;
  int         m_npix;     // pixels seen in the current frame
  logic [7:0] m_ram [D];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_good = 0; m_armed = 0; m_lastvs = 0; m_npix = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_vs"}, out_vsync, 1'b0);
    chk1({tag, "_hs"}, out_hsync, 1'b0);
    chk1({tag, "_v"}, out_valid, 1'b0);
    chk8({tag, "_d"}, out_data, 8'd0);
    chk8({tag, "_prev"}, prev_data, 8'd0);
    chk1({tag, "_ok"}, prev_ok, 1'b0);
    chk1({tag, "_err"}, frame_err, 1'b0);
  endtask

  // One clock cycle: apply inputs, predict outputs, check after the edge.
  task automatic step(input logic vs, input logic hs, input logic v, input logic [7:0] d);
    logic       e_err, e_ok;
    logic [7:0] e_prev;
    in_vsync = vs; in_hsync = hs; in_valid = v; in_data = d;
    e_err = 1'b0;
    if (vs && !m_lastvs) begin
      if (m_active) begin
        e_err  = (m_npix != D);
        m_good = (m_npix == D);
      end else if (m_armed) begin
        m_active = 1;
        m_good   = 0;
      end
      m_npix = 0;
    end
    e_prev = d;
    if (v && vs && m_active) begin
      if (m_npix < D) begin
        if (m_good) e_prev = m_ram[m_npix];
        m_ram[m_npix] = d;
      end
      m_npix++;
    end
    e_ok = m_active && m_good;
    m_lastvs = vs;
    if (!vs) m_armed = 1;
    @(posedge clk);
    #1;
    chk1("out_vsync", out_vsync, vs);
    chk1("out_hsync", out_hsync, hs);
    chk1("out_valid", out_valid, v);
    chk8("out_data", out_data, d);
    chk8("prev_data", prev_data, e_prev);
    chk1("prev_ok", prev_ok, e_ok);
    chk1("frame_err", frame_err, e_err);
  endtask

  function automatic logic [7:0] pix(input int mode, input int base, input int i);
    if (mode == 0) return 8'(base);
    if (mode == 1) return 8'(base + i);
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: constant base, 1: ramp from base, 2: random values
  task automatic frame(input int n, input int mode, input int base, input bit same_start);
    int i;
    repeat (2 + $urandom_range(0, 2)) step(1'b0, rb(), rb(), 8'($urandom_range(0, 255)));
    i = 0;
    if (same_start) begin
      step(1'b1, rb(), 1'b1, pix(mode, base, 0));
      i = 1;
    end else begin
      step(1'b1, rb(), 1'b0, 8'($urandom_range(0, 255)));
    end
    for (; i < n; i++) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 99) < 25) step(1'b1, rb(), 1'b0, 8'($urandom_range(0, 255)));
      end
      step(1'b1, rb(), 1'b1, pix(mode, base, i));
    end
    step(1'b1, rb(), 1'b0, 8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst_n = 1'b0;
    in_vsync = 1'b0; in_hsync = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // first frames after reset, then ramps
    frame(D, 0, 10, 1'b0);
    frame(D, 0, 30, 1'b0);
    frame(D, 1, 0, 1'b0);
    frame(D, 1, 100, 1'b0);
    // short frame while in RUN, then recovery
    frame(6, 2, 0, 1'b0);
    frame(D, 2, 0, 1'b0);
    frame(D, 2, 0, 1'b0);
    // long frame, then FILL->RUN sequence
    frame(10, 1, 50, 1'b0);
    frame(D, 2, 0, 1'b0);
    frame(D, 2, 0, 1'b0);
    // pixel on the vsync rise cycle
    frame(D, 1, 200, 1'b1);
    frame(D, 2, 0, 1'b1);
    frame(D, 2, 0, 1'b0);

    // reset in the middle of a RUN frame
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd77);
    step(1'b1, 1'b0, 1'b1, 8'd78);
    step(1'b1, 1'b1, 1'b1, 8'd79);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("in_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, rb(), 1'b1, 8'($urandom_range(0, 255)));
    frame(D, 2, 0, 1'b0);
    frame(D, 2, 0, 1'b0);
    frame(D, 2, 0, 1'b0);

    // random frame lengths around D
    for (int f = 0; f < 8; f++) frame($urandom_range(D - 1, D + 1), 2, 0, rb());
    frame(D, 2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_prev_buf.md
# frame_prev_buf

On-chip previous-frame store that feeds `frame_diff`. It takes the live 8-bit grey pixel stream and writes each frame into a single-port-style RAM. In the same access it reads back the co-located pixel of the previous frame. It emits the live stream delayed by one cycle together with the aligned previous-frame pixel, so the pair can drive the current-frame and previous-frame inputs of `frame_diff` directly.

## Interface
- `IMG_W`, 320, active pixels per line
- `IMG_H`, 240, active lines per frame
- `DEPTH`, `IMG_W*IMG_H`, RAM words; the address width is `clog2(DEPTH)` and the counter width is that plus 1
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`
- `in_vsync`  in  1  frame active (high during frame); a rising edge marks frame start
- `in_hsync`  in  1  line sync, passed through only
- `in_valid`  in  1  pixel strobe
- `in_data`  in  8  current pixel
- `out_vsync`, `out_hsync`, `out_valid`  out  1 each  inputs delayed 1 cycle
- `out_data`  out  8  `in_data` delayed 1 cycle
- `prev_data`  out  8  previous-frame pixel at the same position, aligned to `out_data`
- `prev_ok`  out  1  high while `prev_data` comes from a complete, correctly sized previous frame
- `frame_err`  out  1  one-cycle pulse when a finished frame's pixel count is not `DEPTH`

## Operation
- State machine with three states:
  - IDLE: entered on reset; waits for the first `in_vsync` rise. Pixels arriving in IDLE are ignored, not written.
  - FILL: the first frame, or a frame after an error, is being written; `prev_ok`=0.
  - RUN: the previous frame is valid; `prev_ok`=1.
- Frame start is detected when `in_vsync`=1 and the registered `vsync_d`=0. At frame start:
  - `addr` clears to 0 and the pixel counter `cnt` clears to 0.
  - `cnt` is then evaluated for the frame that just ended:
    - IDLE -> FILL, with no error check.
    - FILL, `cnt`==`DEPTH` -> RUN.
    - RUN, `cnt`==`DEPTH` -> RUN.
    - FILL or RUN, `cnt`!=`DEPTH` -> FILL, and `frame_err` pulses.
- Pixel access, when `in_valid`=1, `in_vsync`=1 and state is not IDLE:
  - The RAM reads `mem[addr]` and writes `mem[addr]`=`in_data` in the same cycle, read-before-write. The read returns old data.
  - `addr` increments. `cnt` increments and saturates at `DEPTH+1`.
- Overflow: when `addr`==`DEPTH`, further pixels are neither read nor written and `addr` holds. The frame then ends with `cnt`=`DEPTH+1`, which counts as an error.
- `prev_data` source:
  - Equals the RAM read data when `prev_ok`=1 and the access was in range.
  - Otherwise it equals the delayed `in_data`, so the downstream difference is 0.
- `in_valid` with `in_vsync`=0 is passed through but performs no RAM access.
- RAM contents are never cleared. Validity is tracked only through the state.

## Timing
- Latency is 1 cycle from every `in_*` to the corresponding `out_*` / `prev_data`.
- `prev_ok` is registered alongside the delayed data. It changes only on the cycle after a frame start.
- `frame_err` is asserted on the cycle after the `in_vsync` rise, for 1 cycle.
- Reset values:
  - `out_*`=0, `prev_data`=0, `prev_ok`=0, `frame_err`=0.
  - State IDLE, `addr`=0, `cnt`=0, `vsync_d`=0.
- A frame-start cycle with `in_valid`=1: that pixel belongs to the new frame and uses address 0.
- Reset asserted mid-frame: all outputs are 0 immediately (asynchronous) and state returns to IDLE. The remainder of the current frame is ignored until the next `in_vsync` rise.
- Throughput is one pixel per clock with no stall.

## Test plan
Parameters for the bench: `IMG_W`=4, `IMG_H`=2 (`DEPTH`=8).

- **First frames after reset.** Frame A = 8 pixels of 10, then frame B = 8 pixels of 30.
  - During A: `prev_ok`=0, `prev_data`=10.
  - During B: `prev_ok`=1, `prev_data`=10 each cycle, with 1-cycle alignment to `out_data`=30.
- **Ramp check.** Frame C = values 0..7, then frame D = values 100..107. During D, `prev_data` equals 0..7 in order, exactly on the `out_valid` cycles.
- **Short frame.** A frame with 6 pixels while in RUN.
  - `frame_err` pulses once at the next vsync rise.
  - The following frame shows `prev_ok`=0 and `prev_data`=`out_data`.
  - The frame after that returns to `prev_ok`=1.
- **Long frame.** A frame with 10 pixels.
  - Pixels 9-10 are not written.
  - `frame_err` pulses at the next vsync rise.
  - `mem[0..7]` keeps the first 8 pixels; check by the FILL->RUN sequence on the following frames.
- **Same-cycle start.** `in_valid`=1 on the `in_vsync` rise cycle: that pixel is read from and written to address 0.
- **Reset mid-frame.** Assert reset mid-frame in RUN.
  - All outputs read 0 while in reset.
  - After release, pixels before the next vsync rise are ignored.
  - The next full frame shows `prev_ok`=0, and the one after shows `prev_ok`=1.
